// File: rtl/seven_seg_scan_reader_if.sv
// rtl/seven_seg_scan_reader_if.sv - multiplexed seven-segment bus plus reassembled coordinate outputs
interface seven_seg_scan_reader_if;
    logic [6:0]  i_seg;
    logic [2:0]  i_dig_sel;
    logic [11:0] o_coord;
    logic        o_valid;
    logic        o_err;

    modport master (
        output i_seg,
        output i_dig_sel,
        input  o_coord,
        input  o_valid,
        input  o_err
    );

    modport slave (
        input  i_seg,
        input  i_dig_sel,
        output o_coord,
        output o_valid,
        output o_err
    );
endinterface

// File: rtl/seven_seg_scan_reader.sv
// rtl/seven_seg_scan_reader.sv - debounces a scanned 3-digit seven-segment bus and reassembles the 12-bit coordinate
module seven_seg_scan_reader #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    seven_seg_scan_reader_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

    localparam logic [7:0]  C_STABLE   = 8'(STABLE_CNT);
    localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  r_seg;
    logic [2:0]  r_dig;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [15:0] r_tmo;
    logic [2:0]  r_mask;
    logic [11:0] r_nib;
    logic [11:0] r_coord;
    logic        r_valid;
    logic        r_err;

    logic        w_onehot;
    logic        w_same;
    logic        w_acc;
    logic        w_legal;
    logic [3:0]  w_nib;
    logic [2:0]  w_mask_upd;
    logic        w_timeout;
    logic        w_valid_d;
    logic        w_err_d;

    assign w_onehot = (bus.i_dig_sel == 3'b001) || (bus.i_dig_sel == 3'b010) ||
                      (bus.i_dig_sel == 3'b100);
    assign w_same   = (bus.i_seg == r_seg) && (bus.i_dig_sel == r_dig);

    always_comb begin
        w_cnt_next = 8'd0;
        if (!w_onehot)
            w_cnt_next = 8'd0;
        else if (!w_same)
            w_cnt_next = 8'd1;
        else if (r_cnt == C_STABLE)
            w_cnt_next = C_STABLE;
        else
            w_cnt_next = r_cnt + 8'd1;
    end

    // The dwell is accepted only on the transition into saturation; EMIT never overlaps an accept.
    assign w_acc = (w_cnt_next == C_STABLE) && (r_cnt != C_STABLE) && (r_state != S_EMIT);

    // At accept time the incoming sample equals the registered one, so decode the register.
    always_comb begin
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (r_seg)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1011000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_mask_upd = r_mask | r_dig;
    assign w_timeout  = (r_state == S_COLLECT) && (r_tmo == C_TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && w_legal)
                    w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_acc)
                    w_state_next = !w_legal ? S_IDLE :
                                   (w_mask_upd == 3'b111) ? S_EMIT : S_COLLECT;
                else if (w_timeout)
                    w_state_next = S_IDLE;
            end
            S_EMIT:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid_d = (r_state == S_EMIT);
        w_err_d   = w_acc && !w_legal;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seg   <= 7'h7F;
            r_dig   <= 3'b000;
            r_cnt   <= 8'd0;
            r_tmo   <= 16'd0;
            r_mask  <= 3'b000;
            r_nib   <= 12'h000;
            r_coord <= 12'h000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_seg   <= bus.i_seg;
            r_dig   <= bus.i_dig_sel;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_d;
            r_err   <= w_err_d;

            if ((r_state == S_COLLECT) && !w_acc)
                r_tmo <= r_tmo + 16'd1;
            else
                r_tmo <= 16'd0;

            if ((r_state == S_EMIT) || (w_acc && !w_legal) || (w_timeout && !w_acc))
                r_mask <= 3'b000;
            else if (w_acc)
                r_mask <= w_mask_upd;

            if (w_acc && w_legal) begin
                if (r_dig[0]) r_nib[3:0]  <= w_nib;
                if (r_dig[1]) r_nib[7:4]  <= w_nib;
                if (r_dig[2]) r_nib[11:8] <= w_nib;
            end

            if (r_state == S_EMIT)
                r_coord <= r_nib;
        end
    end

    assign bus.o_coord = r_coord;
    assign bus.o_valid = r_valid;
    assign bus.o_err   = r_err;
endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// tb/tb_seven_seg_scan_reader.sv - directed bench for seven_seg_scan_reader
module tb_seven_seg_scan_reader;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_reader_if bus();

    seven_seg_scan_reader #(.STABLE_CNT(4), .TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int v0;
    int e0;
    logic [11:0] last_coord = 12'h000;
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_valid) begin
            n_valid++;
            last_coord = bus.o_coord;
        end
        if (bus.o_err) n_err++;
        if (bus.o_valid && bus.o_err) n_both++;
    end

    task automatic show(input logic [2:0] sel, input logic [6:0] seg, input int n);
        bus.i_dig_sel = sel;
        bus.i_seg     = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(3'b000, 7'h7F, n);
    endtask

    task automatic scan(input logic [11:0] val, input int dwell);
        show(3'b001, seg_tab[val[3:0]], dwell);
        show(3'b010, seg_tab[val[7:4]], dwell);
        show(3'b100, seg_tab[val[11:8]], dwell);
        blank(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h58;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
        bus.i_seg     = 7'h7F;
        bus.i_dig_sel = 3'b000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_coord", 32'(bus.o_coord), 32'h000);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_err",   32'(bus.o_err),   32'h0);
        rst_n = 1'b1;
        blank(2);

        v0 = n_valid; e0 = n_err;
        scan(12'h1A3, 8);
        chk("t1_nvalid", 32'(n_valid - v0), 32'd1);
        chk("t1_coord",  32'(last_coord),   32'h1A3);
        chk("t1_nerr",   32'(n_err - e0),   32'd0);

        v0 = n_valid;
        scan(12'h123, 3);
        chk("t2_short_nvalid", 32'(n_valid - v0), 32'd0);
        show(3'b001, seg_tab[4'hE], 4);
        show(3'b010, seg_tab[4'h0], 4);
        show(3'b100, seg_tab[4'hF], 4);
        @(negedge clk);
        chk("t2_latency_valid", 32'(bus.o_valid), 32'h1);
        chk("t2_latency_coord", 32'(bus.o_coord), 32'hF0E);
        blank(4);
        chk("t2_nvalid", 32'(n_valid - v0), 32'd1);
        chk("t2_coord",  32'(last_coord),   32'hF0E);

        v0 = n_valid; e0 = n_err;
        show(3'b001, seg_tab[4'h7], 8);
        show(3'b010, 7'h7F, 8);
        blank(4);
        chk("t3_nerr",   32'(n_err - e0),   32'd1);
        chk("t3_nvalid", 32'(n_valid - v0), 32'd0);
        scan(12'h2B7, 8);
        chk("t3_clean_nvalid", 32'(n_valid - v0), 32'd1);
        chk("t3_clean_coord",  32'(last_coord),   32'h2B7);
        chk("t3_nerr_after",   32'(n_err - e0),   32'd1);

        v0 = n_valid;
        show(3'b001, seg_tab[4'h4], 8);
        show(3'b010, seg_tab[4'h5], 8);
        show(3'b011, seg_tab[4'h8], 20);
        show(3'b000, seg_tab[4'h8], 20);
        chk("t4_bad_sel_nvalid", 32'(n_valid - v0), 32'd0);
        show(3'b100, seg_tab[4'h6], 8);
        blank(4);
        chk("t4_nvalid", 32'(n_valid - v0), 32'd1);
        chk("t4_coord",  32'(last_coord),   32'h654);

        v0 = n_valid;
        show(3'b001, seg_tab[4'h1], 8);
        show(3'b010, seg_tab[4'h2], 8);
        blank(TMO + 8);
        show(3'b100, seg_tab[4'h3], 8);
        blank(4);
        chk("t5_timeout_nvalid", 32'(n_valid - v0), 32'd0);
        blank(TMO + 8);
        show(3'b010, seg_tab[4'h4], 8);
        show(3'b010, seg_tab[4'h5], 8);
        show(3'b001, seg_tab[4'h9], 8);
        show(3'b100, seg_tab[4'h3], 8);
        blank(4);
        chk("t5_nvalid",   32'(n_valid - v0),   32'd1);
        chk("t5_mid_nib",  32'(last_coord[7:4]), 32'h5);
        chk("t5_coord",    32'(last_coord),     32'h359);

        show(3'b001, seg_tab[4'hA], 8);
        show(3'b010, seg_tab[4'hB], 8);
        blank(2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_coord", 32'(bus.o_coord), 32'h000);
        chk("t6_rst_valid", 32'(bus.o_valid), 32'h0);
        v0 = n_valid;
        show(3'b100, seg_tab[4'hC], 8);
        blank(10);
        chk("t6_single_nvalid", 32'(n_valid - v0), 32'd0);

        for (int n = 0; n < 16; n++) begin
            v0 = n_valid;
            show(3'b100, seg_tab[4'hC], 5);
            show(3'b010, seg_tab[4'h3], 5);
            show(3'b001, seg_tab[n], 5);
            blank(4);
            chk($sformatf("t6_sweep_nvalid_%0d", n), 32'(n_valid - v0), 32'd1);
            chk($sformatf("t6_sweep_coord_%0d", n),  32'(last_coord),   32'hC30 | 32'(n));
        end

        chk("never_both", 32'(n_both), 32'd0);
        chk("total_err",  32'(n_err),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
